// File: rtl/interrupt_ctrl_if.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl_if
// Bundle of the interrupt controller's channel-facing and CPU-facing signals.
//
// Signals:
//   irq_trigger  [NUM_CH] raw per-channel trigger, synchronous to clk
//   irq_mask     [NUM_CH] per-channel enable (1 = may drive the interrupt)
//   irq_ack      [NUM_CH] per-channel clear strobe
//   irq_pending  [NUM_CH] sticky pending bits
//   irq_valid    [1]      any unmasked pending bit set
//   irq_id       [ID_W]   lowest-numbered unmasked pending channel
//   interrupt    [1]      merged interrupt line
//
// Modports:
//   master - the side driving triggers/mask/ack and observing the results
//   slave  - the interrupt controller itself
// -----------------------------------------------------------------------------
interface interrupt_ctrl_if #(
  parameter int NUM_CH = 4
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] irq_trigger;
  logic [NUM_CH-1:0] irq_mask;
  logic [NUM_CH-1:0] irq_ack;
  logic [NUM_CH-1:0] irq_pending;
  logic              irq_valid;
  logic [ID_W-1:0]   irq_id;
  logic              interrupt;

  modport master (
    output irq_trigger, irq_mask, irq_ack,
    input  irq_pending, irq_valid, irq_id, interrupt
  );

  modport slave (
    input  irq_trigger, irq_mask, irq_ack,
    output irq_pending, irq_valid, irq_id, interrupt
  );
endinterface

// File: rtl/interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// interrupt_ctrl
// Multi-channel interrupt generator. Each channel latches a rising edge of its
// trigger into a sticky pending bit; unmasked pending bits are merged into one
// interrupt line (fixed-length pulse or level) and a priority index is
// reported (channel 0 highest).
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    interrupt_ctrl_if.slave (trigger/mask/ack in, pending/valid/id/
//          interrupt out)
//
// Parameters:
//   NUM_CH     number of channels (1..32)
//   PULSE_LEN  pulse width in cycles in pulse mode (1..255)
//   LEVEL_MODE 0 = pulse output, 1 = level output
// -----------------------------------------------------------------------------
module interrupt_ctrl #(
  parameter int NUM_CH     = 4,
  parameter int PULSE_LEN  = 3,
  parameter int LEVEL_MODE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  interrupt_ctrl_if.slave  bus
);
  localparam int ID_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] trig_q, trig_d;
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] trig_edge;
  logic [NUM_CH-1:0] masked;
  logic [ID_W-1:0]   irq_id_c;

  // Edge detect and sticky pending: a new edge always wins over an ack.
  always_comb begin
    trig_d    = bus.irq_trigger;
    trig_edge = bus.irq_trigger & ~trig_q;
    pending_d = trig_edge | (pending_q & ~bus.irq_ack);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig_q    <= '0;
      pending_q <= '0;
    end else begin
      trig_q    <= trig_d;
      pending_q <= pending_d;
    end
  end

  // Lowest set bit wins; scanning downward lets lower indices overwrite.
  always_comb begin
    masked   = pending_q & bus.irq_mask;
    irq_id_c = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (masked[i]) irq_id_c = ID_W'(i);
    end
  end

  assign bus.irq_pending = pending_q;
  assign bus.irq_valid   = |masked;
  assign bus.irq_id      = irq_id_c;

  generate
    if (LEVEL_MODE != 0) begin : g_level
      assign bus.interrupt = |masked;
    end else begin : g_pulse
      localparam int CNT_W = $clog2(PULSE_LEN + 1);

      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             qualify;

      // Only a fresh edge on an unmasked channel (re)loads the counter, so
      // unmasking an already pending channel does not produce a pulse.
      always_comb begin
        qualify = |(trig_edge & bus.irq_mask);
        cnt_d   = cnt_q;
        if (qualify) begin
          cnt_d = CNT_W'(PULSE_LEN);
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      assign bus.interrupt = (cnt_q != '0);
    end
  endgenerate
endmodule

// File: tb/tb_interrupt_ctrl.sv
// -----------------------------------------------------------------------------
// tb_interrupt_ctrl
// Directed bench for interrupt_ctrl: one pulse-mode instance (PULSE_LEN=3) and
// one level-mode instance, both NUM_CH=4. Inputs change and outputs are sampled
// on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_interrupt_ctrl;
  logic clk;
  logic rst_n;

  int tests_run    = 0;
  int tests_failed = 0;

  interrupt_ctrl_if #(.NUM_CH(4)) bus_p ();
  interrupt_ctrl_if #(.NUM_CH(4)) bus_l ();

  interrupt_ctrl #(.NUM_CH(4), .PULSE_LEN(3), .LEVEL_MODE(0)) u_pulse (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_p)
  );

  interrupt_ctrl #(.NUM_CH(4), .PULSE_LEN(3), .LEVEL_MODE(1)) u_level (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_l)
  );

  // 10 ns clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset asserted: every output zero; then released with trigger low.
  task automatic test_reset();
    rst_n = 1'b0;
    bus_p.irq_trigger = 4'b0000; bus_p.irq_mask = 4'b1111; bus_p.irq_ack = 4'b0000;
    bus_l.irq_trigger = 4'b0000; bus_l.irq_mask = 4'b1111; bus_l.irq_ack = 4'b0000;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({bus_p.irq_pending, bus_p.irq_valid, bus_p.irq_id, bus_p.interrupt} !== 8'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got pend=%b valid=%b id=%0d int=%b, want all 0",
               bus_p.irq_pending, bus_p.irq_valid, bus_p.irq_id, bus_p.interrupt);
    end
  endtask

  // One-cycle trigger on channel 2 gives a 3-cycle pulse starting at its edge.
  task automatic test_single_pulse();
    logic [4:0] seen;
    bus_p.irq_trigger = 4'b0100;
    @(negedge clk);
    bus_p.irq_trigger = 4'b0000;
    tests_run++;
    if (bus_p.irq_pending !== 4'b0100 || bus_p.irq_id !== 2'd2 || bus_p.irq_valid !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_status: got pend=%b id=%0d valid=%b, want 0100/2/1",
               bus_p.irq_pending, bus_p.irq_id, bus_p.irq_valid);
    end
    seen[0] = bus_p.interrupt;
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      seen[i] = bus_p.interrupt;
    end
    tests_run++;
    if (seen !== 5'b00111) begin
      tests_failed++;
      $display("[TB] FAIL single_pulse_shape: got %b, want 00111 (LSB first cycle)", seen);
    end
    bus_p.irq_ack = 4'b0100;
    @(negedge clk);
    bus_p.irq_ack = 4'b0000;
    tests_run++;
    if (bus_p.irq_pending !== 4'b0000 || bus_p.irq_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL single_ack_clear: got pend=%b valid=%b, want 0000/0",
               bus_p.irq_pending, bus_p.irq_valid);
    end
  endtask

  // Channel 0 then channel 1 two cycles later: one continuous 5-cycle pulse.
  task automatic test_retrigger();
    logic [6:0] seen;
    bus_p.irq_trigger = 4'b0001;
    @(negedge clk);
    seen[0] = bus_p.interrupt;
    @(negedge clk);
    seen[1] = bus_p.interrupt;
    bus_p.irq_trigger = 4'b0011;
    for (int i = 2; i < 7; i++) begin
      @(negedge clk);
      seen[i] = bus_p.interrupt;
    end
    tests_run++;
    if (seen !== 7'b0011111) begin
      tests_failed++;
      $display("[TB] FAIL retrigger_shape: got %b, want 0011111 (LSB first cycle)", seen);
    end
    tests_run++;
    if (bus_p.irq_id !== 2'd0 || bus_p.irq_pending !== 4'b0011) begin
      tests_failed++;
      $display("[TB] FAIL retrigger_status: got id=%0d pend=%b, want 0/0011",
               bus_p.irq_id, bus_p.irq_pending);
    end
    bus_p.irq_trigger = 4'b0000;
    bus_p.irq_ack     = 4'b1111;
    @(negedge clk);
    bus_p.irq_ack     = 4'b0000;
  endtask

  // Masked edge sets pending silently; unmasking shows it with no pulse.
  task automatic test_mask();
    int highs;
    bus_p.irq_mask    = 4'b1110;
    bus_p.irq_trigger = 4'b0001;
    @(negedge clk);
    tests_run++;
    if (bus_p.irq_pending[0] !== 1'b1 || bus_p.irq_valid !== 1'b0 || bus_p.interrupt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL masked_edge: got pend0=%b valid=%b int=%b, want 1/0/0",
               bus_p.irq_pending[0], bus_p.irq_valid, bus_p.interrupt);
    end
    bus_p.irq_mask = 4'b1111;
    #1;
    tests_run++;
    if (bus_p.irq_valid !== 1'b1 || bus_p.irq_id !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL unmask_same_cycle: got valid=%b id=%0d, want 1/0",
               bus_p.irq_valid, bus_p.irq_id);
    end
    highs = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus_p.interrupt === 1'b1) highs++;
    end
    tests_run++;
    if (highs !== 0) begin
      tests_failed++;
      $display("[TB] FAIL unmask_no_pulse: got %0d interrupt cycles, want 0", highs);
    end
    bus_p.irq_trigger = 4'b0000;
    bus_p.irq_ack     = 4'b0001;
    @(negedge clk);
    bus_p.irq_ack     = 4'b0000;
  endtask

  // Trigger held for 10 cycles: a single pulse; ack mid-way clears for good.
  task automatic test_hold();
    int highs;
    logic pend_mid;
    highs    = 0;
    pend_mid = 1'b0;
    bus_p.irq_trigger = 4'b1000;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus_p.interrupt === 1'b1) highs++;
      if (i == 3) pend_mid = bus_p.irq_pending[3];
      bus_p.irq_ack = (i == 4) ? 4'b1000 : 4'b0000;
    end
    tests_run++;
    if (highs !== 3) begin
      tests_failed++;
      $display("[TB] FAIL hold_single_pulse: got %0d interrupt cycles, want 3", highs);
    end
    tests_run++;
    if (pend_mid !== 1'b1 || bus_p.irq_pending[3] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL hold_ack: got pend3 before=%b after=%b, want 1/0",
               pend_mid, bus_p.irq_pending[3]);
    end
    bus_p.irq_trigger = 4'b0000;
    @(negedge clk);
  endtask

  // Edge and ack together keep pending set; ack alone then clears it.
  task automatic test_set_wins();
    bus_p.irq_trigger = 4'b0010;
    bus_p.irq_ack     = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (bus_p.irq_pending[1] !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL set_wins_over_ack: got pend1=%b, want 1", bus_p.irq_pending[1]);
    end
    @(negedge clk);
    tests_run++;
    if (bus_p.irq_pending[1] !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL ack_alone_clears: got pend1=%b, want 0", bus_p.irq_pending[1]);
    end
    bus_p.irq_trigger = 4'b0000;
    bus_p.irq_ack     = 4'b0000;
    repeat (4) @(negedge clk);
  endtask

  // Level-mode instance: interrupt follows unmasked pending, priority to ch1.
  task automatic test_level_mode();
    bus_l.irq_trigger = 4'b0110;
    #1;
    tests_run++;
    if (bus_l.interrupt !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL level_latency: got int=%b before clock edge, want 0", bus_l.interrupt);
    end
    @(negedge clk);
    bus_l.irq_trigger = 4'b0000;
    tests_run++;
    if (bus_l.interrupt !== 1'b1 || bus_l.irq_id !== 2'd1) begin
      tests_failed++;
      $display("[TB] FAIL level_assert: got int=%b id=%0d, want 1/1", bus_l.interrupt, bus_l.irq_id);
    end
    bus_l.irq_ack = 4'b0010;
    @(negedge clk);
    tests_run++;
    if (bus_l.interrupt !== 1'b1 || bus_l.irq_id !== 2'd2) begin
      tests_failed++;
      $display("[TB] FAIL level_ack1: got int=%b id=%0d, want 1/2", bus_l.interrupt, bus_l.irq_id);
    end
    bus_l.irq_ack = 4'b0100;
    @(negedge clk);
    bus_l.irq_ack = 4'b0000;
    tests_run++;
    if (bus_l.interrupt !== 1'b0 || bus_l.irq_valid !== 1'b0 || bus_l.irq_id !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL level_ack2: got int=%b valid=%b id=%0d, want 0/0/0",
               bus_l.interrupt, bus_l.irq_valid, bus_l.irq_id);
    end
  endtask

  // Reset asserted mid-pulse clears interrupt and pending without a clock.
  task automatic test_async_reset();
    bus_p.irq_trigger = 4'b0100;
    @(negedge clk);
    bus_p.irq_trigger = 4'b0000;
    tests_run++;
    if (bus_p.interrupt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL async_pre: got int=%b, want 1", bus_p.interrupt);
    end
    #1 rst_n = 1'b0;
    #1;
    tests_run++;
    if (bus_p.interrupt !== 1'b0 || bus_p.irq_pending !== 4'b0000) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got int=%b pend=%b, want 0/0000",
               bus_p.interrupt, bus_p.irq_pending);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single_pulse();
    test_retrigger();
    test_mask();
    test_hold();
    test_set_wins();
    test_level_mode();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/interrupt_ctrl.md
Name: interrupt_ctrl

Overview:
- Multi-channel, parametrised interrupt generator for the CPU-facing side of the design.
- Per channel: detects a rising edge on a trigger and latches it in a sticky pending bit, which a per-channel mask gates.
- Merges all channels into one interrupt line. The line is either a fixed-length pulse (length set by PULSE_LEN) or a level held until acknowledge.
- Also reports the lowest-numbered active channel so the handler can service sources in priority order.

Parameters:
- NUM_CH, 4, number of interrupt channels (1..32).
- PULSE_LEN, 3, interrupt pulse width in clock cycles in pulse mode (1..255).
- LEVEL_MODE, 0, 0 = pulse output, 1 = level output held while any unmasked pending bit is set.
- ID_W, $clog2(NUM_CH) (minimum 1), width of irq_id.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- irq_trigger  in  NUM_CH  raw trigger per channel, synchronous to clk.
- irq_mask  in  NUM_CH  per-channel enable; 1 = channel may drive interrupt.
- irq_ack  in  NUM_CH  per-channel clear strobe; 1 for one or more cycles clears pending.
- irq_pending  out  NUM_CH  sticky pending bits, registered.
- irq_valid  out  1  high when (irq_pending & irq_mask) is non-zero.
- irq_id  out  ID_W  index of lowest set bit of (irq_pending & irq_mask); 0 when irq_valid=0.
- interrupt  out  1  merged interrupt line to the CPU.

Behaviour:
- Reset (rst_n=0, async):
  - trig_q, irq_pending and the pulse counter are all cleared.
  - interrupt=0, irq_valid=0, irq_id=0.
- Edge detect: trig_q[i] <= irq_trigger[i] each cycle. edge[i] = irq_trigger[i] & ~trig_q[i].
  - Because trig_q resets to 0, a trigger already high when reset releases counts as an edge on the first clock.
- Pending update per channel, at each rising edge:
  - edge=1: pending <= 1. This holds whether ack is 0 or 1, so set wins over a simultaneous ack.
  - edge=0 and ack=1: pending <= 0.
  - otherwise: pending holds its value.
  - Pending sets even when the channel is masked.
- Qualifying event: any i with edge[i] & irq_mask[i].
  - Unmasking a channel that is already pending is not an event in pulse mode.
- Pulse mode (LEVEL_MODE=0):
  - Counter width is $clog2(PULSE_LEN+1).
  - On a qualifying event the counter loads PULSE_LEN. Otherwise it decrements when non-zero, saturating at 0.
  - interrupt = (counter != 0), registered.
  - Timing: a trigger first sampled high at clock edge k gives interrupt high from edge k to edge k+PULSE_LEN, which is exactly PULSE_LEN cycles. This is 1-cycle latency from the trigger becoming high before edge k.
  - Retrigger: a new qualifying event while the counter is non-zero reloads it, so the pulse extends to PULSE_LEN cycles after the last event. There is no gap and no double pulse.
  - irq_ack does not shorten an active pulse.
- Level mode (LEVEL_MODE=1):
  - interrupt = irq_valid, taken from the registered pending bits, with the same 1-cycle latency.
  - interrupt deasserts in the cycle after the ack that clears the last unmasked pending bit.
  - Masking a pending channel drops its contribution in the same cycle, since the path is combinational from mask.
  - In this mode the counter is unused; tie it off.
- irq_valid and irq_id:
  - Combinational from irq_pending and irq_mask, in both modes.
  - Fixed priority: channel 0 is highest.
- irq_trigger must already be synchronous to clk. Any CDC synchronisers sit upstream.

Test Plan:
- Reset release, NUM_CH=4, PULSE_LEN=3, LEVEL_MODE=0, mask=4'b1111, trigger=0 -> all outputs 0. Then pulse trigger[2] high for 1 cycle -> irq_pending=4'b0100, irq_id=2, irq_valid=1, interrupt high for exactly 3 cycles starting 1 cycle after the trigger.
- Trigger[0] rises, then trigger[1] rises 2 cycles later -> interrupt stays high continuously for 5 cycles total, irq_id=0, irq_pending=4'b0011.
- mask=4'b1110, trigger[0] rises -> irq_pending[0]=1, irq_valid=0, interrupt stays 0. Then set mask[0]=1 -> irq_valid=1 and irq_id=0 in the same cycle, with no interrupt pulse.
- Hold trigger[3] high for 10 cycles -> only one 3-cycle pulse and one pending set. An ack[3] during the high period clears pending, and it stays cleared.
- Simultaneous edge and ack on channel 1 -> irq_pending[1] remains 1. An ack alone on the next cycle -> irq_pending[1]=0.
- LEVEL_MODE=1: trigger[1] and trigger[2] pending -> interrupt=1 and irq_id=1. ack[1] -> irq_id=2 and interrupt still 1. ack[2] -> interrupt=0 next cycle. Assert rst_n=0 mid-pulse in pulse mode -> interrupt and pending drop immediately, without waiting for a clock.
